// File: rtl/pc_sequencer.sv
// Next-PC controller: arbitrates exception, eret, branch, jump, stall and sequential
// fetch each cycle and drives registered addr/PC_Write/flush plus EPC/cause state.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_4180,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned STALL_MAX    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        stall_req,
  input  logic        branch_req,
  input  logic [31:0] branch_target,
  input  logic        jump_req,
  input  logic [31:0] jump_target,
  input  logic        exc_req,
  input  logic        eret_req,
  output logic [31:0] addr,
  output logic [2:0]  PC_Write,
  output logic        flush,
  output logic [31:0] epc,
  output logic        exc_active,
  output logic [1:0]  cause
);

  localparam int unsigned SCW = $clog2(STALL_MAX + 1);
  localparam int unsigned FCW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [2:0]  PCW_LOAD = 3'b111;
  localparam logic [2:0]  PCW_HOLD = 3'b000;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_STALL, S_FLUSH} state_e;
  typedef enum logic [2:0] {A_BOOT, A_EXC, A_DROP, A_ERET, A_BRANCH, A_JUMP, A_HOLD, A_SEQ} act_e;

  state_e          state_q, state_d;
  logic [SCW-1:0]  stall_cnt_q, stall_cnt_d;
  logic [FCW-1:0]  flush_cnt_q, flush_cnt_d;
  logic [31:0]     addr_d, epc_d;
  logic [2:0]      pcw_d;
  logic            flush_d, exc_active_d;
  logic [1:0]      cause_d;

  act_e            act_c;
  logic [1:0]      exc_cause_c;
  logic [31:0]     sel_target_c;
  logic            misalign_c;
  logic            ext_exc_c;
  logic            stall_max_c;
  logic [SCW-1:0]  stall_inc_c;

  assign sel_target_c = branch_req ? branch_target : jump_target;
  assign misalign_c   = (branch_req | jump_req) & (sel_target_c[1:0] != 2'b00);
  assign ext_exc_c    = exc_req & ~exc_active;
  assign stall_max_c  = (stall_cnt_q == SCW'(STALL_MAX));
  assign stall_inc_c  = stall_max_c ? stall_cnt_q : stall_cnt_q + SCW'(1);

  // Priority decode of this cycle's action; squashed requests are ignored in FLUSH.
  always_comb begin
    act_c       = A_SEQ;
    exc_cause_c = 2'd0;
    case (state_q)
      S_BOOT:  act_c = A_BOOT;
      S_FLUSH: begin
        if (ext_exc_c) begin
          act_c       = A_EXC;
          exc_cause_c = 2'd1;
        end
      end
      default: begin
        if (ext_exc_c) begin
          act_c       = A_EXC;
          exc_cause_c = 2'd1;
        end else if (misalign_c && !exc_active) begin
          act_c       = A_EXC;
          exc_cause_c = 2'd2;
        end else if (misalign_c) begin
          act_c = A_DROP;
        end else if (eret_req && exc_active) begin
          act_c = A_ERET;
        end else if (branch_req) begin
          act_c = A_BRANCH;
        end else if (jump_req) begin
          act_c = A_JUMP;
        end else if (stall_req) begin
          if (stall_max_c && !exc_active) begin
            act_c       = A_EXC;
            exc_cause_c = 2'd3;
          end else begin
            act_c = A_HOLD;
          end
        end
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_BOOT;
    else        state_q <= state_d;
  end

  // Next-state and counter logic
  always_comb begin
    state_d     = S_RUN;
    stall_cnt_d = '0;
    flush_cnt_d = flush_cnt_q;
    case (act_c)
      A_EXC, A_ERET, A_BRANCH, A_JUMP: begin
        state_d     = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
        flush_cnt_d = FCW'(FLUSH_CYCLES - 1);
      end
      A_DROP:  stall_cnt_d = stall_req ? stall_inc_c : '0;
      A_HOLD: begin
        state_d     = S_STALL;
        stall_cnt_d = stall_inc_c;
      end
      A_SEQ: begin
        if (state_q == S_FLUSH) begin
          flush_cnt_d = flush_cnt_q - FCW'(1);
          state_d     = (flush_cnt_q > FCW'(1)) ? S_FLUSH : S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Output next values
  always_comb begin
    addr_d       = pc_in + 32'd4;
    pcw_d        = PCW_LOAD;
    flush_d      = 1'b0;
    epc_d        = epc;
    exc_active_d = exc_active;
    cause_d      = cause;
    case (act_c)
      A_BOOT:   addr_d = RESET_PC;
      A_EXC: begin
        addr_d       = EXC_VECTOR;
        flush_d      = 1'b1;
        epc_d        = pc_in;
        exc_active_d = 1'b1;
        cause_d      = exc_cause_c;
      end
      A_DROP, A_HOLD: begin
        addr_d = pc_in;
        pcw_d  = PCW_HOLD;
      end
      A_ERET: begin
        addr_d       = epc;
        flush_d      = 1'b1;
        exc_active_d = 1'b0;
        cause_d      = 2'd0;
      end
      A_BRANCH: begin
        addr_d  = branch_target;
        flush_d = 1'b1;
      end
      A_JUMP: begin
        addr_d  = jump_target;
        flush_d = 1'b1;
      end
      default:  flush_d = (state_q == S_FLUSH);
    endcase
  end

  // Registered outputs and counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr        <= RESET_PC;
      PC_Write    <= PCW_HOLD;
      flush       <= 1'b0;
      epc         <= '0;
      exc_active  <= 1'b0;
      cause       <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      addr        <= addr_d;
      PC_Write    <= pcw_d;
      flush       <= flush_d;
      epc         <= epc_d;
      exc_active  <= exc_active_d;
      cause       <= cause_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations, then a
// randomized run checked against a priority-rule reference model.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam int          FC         = 2;
  localparam int          SMAX       = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in, branch_target, jump_target;
  logic        stall_req, branch_req, jump_req, exc_req, eret_req;
  logic [31:0] addr, epc;
  logic [2:0]  PC_Write;
  logic        flush, exc_active;
  logic [1:0]  cause;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  bit          m_boot, m_exc;
  int          m_flush_left, m_stall;
  logic [31:0] m_epc, e_addr;
  logic [1:0]  m_cause;
  logic [2:0]  e_pcw;
  logic        e_flush;

  pc_sequencer #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR),
                 .FLUSH_CYCLES(FC), .STALL_MAX(SMAX)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .stall_req(stall_req),
    .branch_req(branch_req), .branch_target(branch_target),
    .jump_req(jump_req), .jump_target(jump_target), .exc_req(exc_req),
    .eret_req(eret_req), .addr(addr), .PC_Write(PC_Write), .flush(flush),
    .epc(epc), .exc_active(exc_active), .cause(cause));

  always #5 clk = ~clk;

  task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                       input logic jr, input logic [31:0] jt,
                       input logic ex, input logic er, input logic [31:0] pc);
    stall_req = st; branch_req = br; branch_target = bt;
    jump_req = jr; jump_target = jt; exc_req = ex; eret_req = er; pc_in = pc;
  endtask

  task automatic idle(input logic [31:0] pc);
    drive(0, 0, 32'h0, 0, 32'h0, 0, 0, pc);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle(32'h0);
    tick(); tick();
    n_cmp++;
    if ({addr, PC_Write, flush, epc, exc_active, cause} !== {RESET_PC, 3'b000, 1'b0, 32'h0, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL reset_vals: got addr=%h pcw=%b flush=%b epc=%h exc=%b cause=%0d want addr=%h pcw=000 rest 0",
               addr, PC_Write, flush, epc, exc_active, cause, RESET_PC);
    end
    reset = 1'b1;
    drive(0, 0, 32'h0, 1, 32'h5000, 1, 0, 32'h1234);
    tick();
    n_cmp++;
    if ({addr, PC_Write, flush, exc_active, cause} !== {32'h3000, 3'b111, 1'b0, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL boot_cycle: got addr=%h pcw=%b flush=%b exc=%b cause=%0d want addr=00003000 pcw=111 flush=0 exc=0 cause=0",
               addr, PC_Write, flush, exc_active, cause);
    end
    for (int i = 0; i < 4; i++) begin
      idle(32'h3000 + 32'(4 * i));
      tick();
      n_cmp++;
      if ({addr, PC_Write, flush} !== {32'h3004 + 32'(4 * i), 3'b111, 1'b0}) begin
        n_fail++;
        $display("FAIL seq_fetch[%0d]: got addr=%h pcw=%b flush=%b want addr=%h pcw=111 flush=0",
                 i, addr, PC_Write, flush, 32'h3004 + 32'(4 * i));
      end
    end
    idle(32'hFFFF_FFFC);
    tick();
    n_cmp++;
    if ({addr, PC_Write} !== {32'h0, 3'b111}) begin
      n_fail++;
      $display("FAIL seq_wrap: got addr=%h pcw=%b want addr=00000000 pcw=111", addr, PC_Write);
    end
  endtask

  task automatic test_branch_jump();
    drive(0, 1, 32'h3100, 1, 32'h3200, 0, 0, 32'h3010);
    tick();
    n_cmp++;
    if ({addr, PC_Write, flush} !== {32'h3100, 3'b111, 1'b1}) begin
      n_fail++;
      $display("FAIL branch_beats_jump: got addr=%h pcw=%b flush=%b want addr=00003100 pcw=111 flush=1", addr, PC_Write, flush);
    end
    drive(0, 0, 32'h0, 1, 32'h3300, 0, 0, 32'h3100);
    tick();
    n_cmp++;
    if ({addr, PC_Write, flush} !== {32'h3104, 3'b111, 1'b1}) begin
      n_fail++;
      $display("FAIL jump_in_flush: got addr=%h pcw=%b flush=%b want addr=00003104 pcw=111 flush=1", addr, PC_Write, flush);
    end
    idle(32'h3104);
    tick();
    n_cmp++;
    if ({addr, PC_Write, flush} !== {32'h3108, 3'b111, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_end: got addr=%h pcw=%b flush=%b want addr=00003108 pcw=111 flush=0", addr, PC_Write, flush);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h3020);
      tick();
      n_cmp++;
      if ({addr, PC_Write, flush} !== {32'h3020, 3'b000, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got addr=%h pcw=%b flush=%b want addr=00003020 pcw=000 flush=0", i, addr, PC_Write, flush);
      end
    end
    idle(32'h3020);
    tick();
    n_cmp++;
    if ({addr, PC_Write} !== {32'h3024, 3'b111}) begin
      n_fail++;
      $display("FAIL stall_release: got addr=%h pcw=%b want addr=00003024 pcw=111", addr, PC_Write);
    end
    for (int i = 0; i < SMAX; i++) begin
      drive(1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h3020);
      tick();
      n_cmp++;
      if ({PC_Write, exc_active} !== {3'b000, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_long[%0d]: got pcw=%b exc=%b want pcw=000 exc=0", i, PC_Write, exc_active);
      end
    end
    tick();
    n_cmp++;
    if ({addr, PC_Write, flush, epc, exc_active, cause} !== {EXC_VECTOR, 3'b111, 1'b1, 32'h3020, 1'b1, 2'd3}) begin
      n_fail++;
      $display("FAIL watchdog: got addr=%h pcw=%b flush=%b epc=%h exc=%b cause=%0d want addr=00004180 pcw=111 flush=1 epc=00003020 exc=1 cause=3",
               addr, PC_Write, flush, epc, exc_active, cause);
    end
    idle(32'h4180); tick();
    drive(0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h4184);
    tick();
    n_cmp++;
    if ({addr, flush, exc_active, cause} !== {32'h3020, 1'b1, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL eret_from_wd: got addr=%h flush=%b exc=%b cause=%0d want addr=00003020 flush=1 exc=0 cause=0",
               addr, flush, exc_active, cause);
    end
    idle(32'h3020); tick();
  endtask

  task automatic test_exception();
    drive(0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h3040);
    tick();
    n_cmp++;
    if ({addr, PC_Write, flush, epc, exc_active, cause} !== {EXC_VECTOR, 3'b111, 1'b1, 32'h3040, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL exc_entry: got addr=%h pcw=%b flush=%b epc=%h exc=%b cause=%0d want addr=00004180 pcw=111 flush=1 epc=00003040 exc=1 cause=1",
               addr, PC_Write, flush, epc, exc_active, cause);
    end
    drive(0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h4180); tick();
    drive(0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h4184); tick();
    n_cmp++;
    if ({addr, flush, epc, exc_active, cause} !== {32'h4188, 1'b0, 32'h3040, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL nested_exc_ignored: got addr=%h flush=%b epc=%h exc=%b cause=%0d want addr=00004188 flush=0 epc=00003040 exc=1 cause=1",
               addr, flush, epc, exc_active, cause);
    end
    for (int i = 0; i < SMAX + 4; i++) begin
      drive(1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h4188);
      tick();
      n_cmp++;
      if ({addr, PC_Write, exc_active, cause} !== {32'h4188, 3'b000, 1'b1, 2'd1}) begin
        n_fail++;
        $display("FAIL stall_sat[%0d]: got addr=%h pcw=%b exc=%b cause=%0d want addr=00004188 pcw=000 exc=1 cause=1",
                 i, addr, PC_Write, exc_active, cause);
      end
    end
    drive(0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h418C);
    tick();
    n_cmp++;
    if ({addr, PC_Write, flush, epc, exc_active, cause} !== {32'h3040, 3'b111, 1'b1, 32'h3040, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL eret: got addr=%h pcw=%b flush=%b epc=%h exc=%b cause=%0d want addr=00003040 pcw=111 flush=1 epc=00003040 exc=0 cause=0",
               addr, PC_Write, flush, epc, exc_active, cause);
    end
    drive(0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h3040); tick();
    drive(0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h3044); tick();
    n_cmp++;
    if ({addr, PC_Write, flush, exc_active} !== {32'h3048, 3'b111, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL eret_inactive: got addr=%h pcw=%b flush=%b exc=%b want addr=00003048 pcw=111 flush=0 exc=0",
               addr, PC_Write, flush, exc_active);
    end
  endtask

  task automatic test_misaligned();
    drive(0, 0, 32'h0, 1, 32'h3102, 0, 0, 32'h3050);
    tick();
    n_cmp++;
    if ({addr, flush, epc, exc_active, cause} !== {EXC_VECTOR, 1'b1, 32'h3050, 1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL misaligned_jump: got addr=%h flush=%b epc=%h exc=%b cause=%0d want addr=00004180 flush=1 epc=00003050 exc=1 cause=2",
               addr, flush, epc, exc_active, cause);
    end
    idle(32'h4180); tick();
    drive(0, 0, 32'h0, 1, 32'h3102, 0, 0, 32'h4184);
    tick();
    n_cmp++;
    if ({PC_Write, flush, epc, exc_active, cause} !== {3'b000, 1'b0, 32'h3050, 1'b1, 2'd2}) begin
      n_fail++;
      $display("FAIL misaligned_dropped: got pcw=%b flush=%b epc=%h exc=%b cause=%0d want pcw=000 flush=0 epc=00003050 exc=1 cause=2",
               PC_Write, flush, epc, exc_active, cause);
    end
    drive(0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h4184); tick();
    idle(32'h3050); tick();
    drive(0, 1, 32'h3101, 1, 32'h3200, 0, 0, 32'h3054);
    tick();
    n_cmp++;
    if ({addr, epc, cause} !== {EXC_VECTOR, 32'h3054, 2'd2}) begin
      n_fail++;
      $display("FAIL misaligned_branch: got addr=%h epc=%h cause=%0d want addr=00004180 epc=00003054 cause=2", addr, epc, cause);
    end
    idle(32'h4180); tick();
    drive(0, 0, 32'h0, 0, 32'h0, 0, 1, 32'h4184); tick();
    idle(32'h3054); tick();
    drive(0, 1, 32'h3200, 1, 32'h3203, 0, 0, 32'h3058);
    tick();
    n_cmp++;
    if ({addr, flush, exc_active, cause} !== {32'h3200, 1'b1, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL aligned_branch_sel: got addr=%h flush=%b exc=%b cause=%0d want addr=00003200 flush=1 exc=0 cause=0",
               addr, flush, exc_active, cause);
    end
  endtask

  task automatic test_reset_midflush();
    drive(0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h3300);
    tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({addr, PC_Write, flush, epc, exc_active, cause} !== {RESET_PC, 3'b000, 1'b0, 32'h0, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL async_reset: got addr=%h pcw=%b flush=%b epc=%h exc=%b cause=%0d want addr=00003000 pcw=000 rest 0",
               addr, PC_Write, flush, epc, exc_active, cause);
    end
    idle(32'h5000);
    tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({addr, PC_Write, flush} !== {RESET_PC, 3'b111, 1'b0}) begin
      n_fail++;
      $display("FAIL reboot: got addr=%h pcw=%b flush=%b want addr=00003000 pcw=111 flush=0", addr, PC_Write, flush);
    end
  endtask

  task automatic m_enter_exc(input logic [1:0] c);
    e_addr = EXC_VECTOR; e_pcw = 3'b111; e_flush = 1'b1;
    m_epc = pc_in; m_exc = 1; m_cause = c; m_flush_left = FC - 1; m_stall = 0;
  endtask

  task automatic m_redirect(input logic [31:0] t);
    e_addr = t; e_pcw = 3'b111; e_flush = 1'b1; m_flush_left = FC - 1; m_stall = 0;
  endtask

  // Expected outputs for one posedge, from the arbitration rules.
  task automatic model_step();
    logic [31:0] tgt;
    bit          mis;
    tgt = branch_req ? branch_target : jump_target;
    mis = (branch_req || jump_req) && (tgt[1:0] != 2'b00);
    if (m_boot) begin
      e_addr = RESET_PC; e_pcw = 3'b111; e_flush = 1'b0; m_boot = 0; m_stall = 0;
    end else if (m_flush_left > 0) begin
      m_stall = 0;
      if (exc_req && !m_exc) m_enter_exc(2'd1);
      else begin
        e_addr = pc_in + 32'd4; e_pcw = 3'b111; e_flush = 1'b1; m_flush_left--;
      end
    end else if (exc_req && !m_exc) m_enter_exc(2'd1);
    else if (mis && !m_exc) m_enter_exc(2'd2);
    else if (mis) begin
      e_addr = pc_in; e_pcw = 3'b000; e_flush = 1'b0;
      m_stall = stall_req ? ((m_stall < SMAX) ? m_stall + 1 : SMAX) : 0;
    end else if (eret_req && m_exc) begin
      m_redirect(m_epc); m_exc = 0; m_cause = 2'd0;
    end else if (branch_req) m_redirect(branch_target);
    else if (jump_req) m_redirect(jump_target);
    else if (stall_req && m_stall == SMAX && !m_exc) m_enter_exc(2'd3);
    else if (stall_req) begin
      e_addr = pc_in; e_pcw = 3'b000; e_flush = 1'b0;
      m_stall = (m_stall < SMAX) ? m_stall + 1 : SMAX;
    end else begin
      e_addr = pc_in + 32'd4; e_pcw = 3'b111; e_flush = 1'b0; m_stall = 0;
    end
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(7) == 0) t[1:0] = 2'($urandom_range(3, 1));
    return t;
  endfunction

  task automatic test_random();
    logic st;
    reset = 1'b0;
    idle(32'h0);
    tick();
    reset = 1'b1;
    m_boot = 1; m_exc = 0; m_flush_left = 0; m_stall = 0; m_epc = 32'h0; m_cause = 2'd0;
    st = 1'b0;
    for (int i = 0; i < 600; i++) begin
      st = ($urandom_range(9) < 8) ? st : ~st;
      drive(st, $urandom_range(99) < 10, rand_target(), $urandom_range(99) < 10, rand_target(),
            $urandom_range(99) < 4, $urandom_range(99) < 12, $urandom & 32'hFFFF_FFFC);
      model_step();
      tick();
      n_cmp++;
      if ({addr, PC_Write, flush, epc, exc_active, cause} !== {e_addr, e_pcw, e_flush, m_epc, m_exc, m_cause}) begin
        n_fail++;
        $display("FAIL random[%0d]: got addr=%h pcw=%b flush=%b epc=%h exc=%b cause=%0d want addr=%h pcw=%b flush=%b epc=%h exc=%b cause=%0d",
                 i, addr, PC_Write, flush, epc, exc_active, cause, e_addr, e_pcw, e_flush, m_epc, m_exc, m_cause);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    idle(32'h0);
    #1;
    test_reset();
    test_branch_jump();
    test_stall();
    test_exception();
    test_misaligned();
    test_reset_midflush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
